// File: rtl/imm_ext_pipe_if.sv
// ---------------------------------------------------------------------------------------------
// imm_ext_pipe_if
//
// Handshake bundle for the pipelined immediate extender. Carries both the upstream (ID side)
// request channel and the downstream (EX side) result channel.
//
// Signals:
//   in_valid / in_ready     upstream valid/ready
//   imm_in, ExtOp, tag_in   raw immediate, extension mode, sideband tag
//   out_valid / out_ready   downstream valid/ready
//   imm_out, tag_out        extended immediate and its tag
//   ext_err                 illegal-mode flag (present only when IMM_EXT_ERR_EN is defined)
//
// Modports:
//   slave  - the extender itself (consumes requests, produces results)
//   master - the environment (produces requests, consumes results)
// ---------------------------------------------------------------------------------------------
interface imm_ext_pipe_if #(
  parameter int unsigned IMM_W  = 16,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned TAG_W  = 8
);

  logic              in_valid;
  logic              in_ready;
  logic [IMM_W-1:0]  imm_in;
  logic [2:0]        ExtOp;
  logic [TAG_W-1:0]  tag_in;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] imm_out;
  logic [TAG_W-1:0]  tag_out;
`ifdef IMM_EXT_ERR_EN
  logic              ext_err;
`endif

  modport slave (
    input  in_valid, imm_in, ExtOp, tag_in, out_ready,
`ifdef IMM_EXT_ERR_EN
    output ext_err,
`endif
    output in_ready, out_valid, imm_out, tag_out
  );

  modport master (
    output in_valid, imm_in, ExtOp, tag_in, out_ready,
`ifdef IMM_EXT_ERR_EN
    input  ext_err,
`endif
    input  in_ready, out_valid, imm_out, tag_out
  );

endinterface

// File: rtl/imm_ext_pipe.sv
// ---------------------------------------------------------------------------------------------
// imm_ext_pipe
//
// Pipelined ID-stage immediate extender. The raw immediate is extended combinationally on the
// input side and registered into an output register (OR). A one-entry skid register (SK)
// catches a transaction accepted while OR is stalled, so EX back-pressure never drops data.
// The OR/SK pair behaves as a strict 2-deep FIFO whose head is presented on the output.
//
// Modes (ExtOp): 000 zero-ext, 001 sign-ext, 010 load-upper, 011 branch offset (sign-ext << 2),
//                100 shift amount (imm_in[10:6]), 101-111 illegal (result 0).
//
// Ports:
//   clk      rising-edge clock
//   reset    synchronous active-high reset
//   flush    synchronous flush; drops every held transaction and any same-cycle accept
//   pipe_io  imm_ext_pipe_if.slave handshake bundle (see the interface header)
//
// Optional feature: define IMM_EXT_ERR_EN to add the ext_err flag, stored with each
// transaction and raised alongside the result of an illegal ExtOp.
// ---------------------------------------------------------------------------------------------
module imm_ext_pipe #(
  parameter int unsigned IMM_W  = 16,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned TAG_W  = 8
) (
  input logic           clk,
  input logic           reset,
  input logic           flush,
  imm_ext_pipe_if.slave pipe_io
);

  typedef enum logic [2:0] {
    ExtZero   = 3'b000,
    ExtSign   = 3'b001,
    ExtUpper  = 3'b010,
    ExtBranch = 3'b011,
    ExtShamt  = 3'b100
  } ext_op_e;

  // -------------------------------------------------------------------------------------------
  // Extension datapath (input side)
  // -------------------------------------------------------------------------------------------
  logic [DATA_W-1:0] sext;
  logic [DATA_W-1:0] ext_val;
`ifdef IMM_EXT_ERR_EN
  logic              ext_illegal;
`endif

  always_comb begin
    sext    = {{(DATA_W-IMM_W){pipe_io.imm_in[IMM_W-1]}}, pipe_io.imm_in};
    ext_val = '0;
`ifdef IMM_EXT_ERR_EN
    ext_illegal = 1'b0;
`endif
    case (pipe_io.ExtOp)
      ExtZero:   ext_val = {{(DATA_W-IMM_W){1'b0}}, pipe_io.imm_in};
      ExtSign:   ext_val = sext;
      ExtUpper:  ext_val = {pipe_io.imm_in, {(DATA_W-IMM_W){1'b0}}};
      // Top two bits of the sign-extended value fall off the end.
      ExtBranch: ext_val = {sext[DATA_W-3:0], 2'b00};
      ExtShamt:  ext_val = {{(DATA_W-5){1'b0}}, pipe_io.imm_in[10:6]};
      default: begin
        ext_val = '0;
`ifdef IMM_EXT_ERR_EN
        ext_illegal = 1'b1;
`endif
      end
    endcase
  end

  // -------------------------------------------------------------------------------------------
  // Output register and skid register
  // -------------------------------------------------------------------------------------------
  logic              or_valid_q, or_valid_d;
  logic [DATA_W-1:0] or_data_q,  or_data_d;
  logic [TAG_W-1:0]  or_tag_q,   or_tag_d;
  logic              sk_valid_q, sk_valid_d;
  logic [DATA_W-1:0] sk_data_q,  sk_data_d;
  logic [TAG_W-1:0]  sk_tag_q,   sk_tag_d;
`ifdef IMM_EXT_ERR_EN
  logic              or_err_q,   or_err_d;
  logic              sk_err_q,   sk_err_d;
`endif

  logic accept;
  logic consume;

  // in_ready depends only on registered state, so there is no comb path from out_ready.
  assign accept  = pipe_io.in_valid & ~sk_valid_q;
  assign consume = or_valid_q & pipe_io.out_ready;

  always_comb begin
    or_valid_d = or_valid_q;
    or_data_d  = or_data_q;
    or_tag_d   = or_tag_q;
    sk_valid_d = sk_valid_q;
    sk_data_d  = sk_data_q;
    sk_tag_d   = sk_tag_q;
`ifdef IMM_EXT_ERR_EN
    or_err_d   = or_err_q;
    sk_err_d   = sk_err_q;
`endif

    if (flush) begin
      // Flush mirrors reset: everything held (and any accept this cycle) is dropped.
      or_valid_d = 1'b0;
      or_data_d  = '0;
      or_tag_d   = '0;
      sk_valid_d = 1'b0;
      sk_data_d  = '0;
      sk_tag_d   = '0;
`ifdef IMM_EXT_ERR_EN
      or_err_d   = 1'b0;
      sk_err_d   = 1'b0;
`endif
    end else if (!or_valid_q || consume) begin
      // OR is free this cycle.
      if (sk_valid_q) begin
        or_valid_d = 1'b1;
        or_data_d  = sk_data_q;
        or_tag_d   = sk_tag_q;
`ifdef IMM_EXT_ERR_EN
        or_err_d   = sk_err_q;
`endif
        sk_valid_d = accept;
        if (accept) begin
          sk_data_d = ext_val;
          sk_tag_d  = pipe_io.tag_in;
`ifdef IMM_EXT_ERR_EN
          sk_err_d  = ext_illegal;
`endif
        end
      end else begin
        or_valid_d = accept;
        if (accept) begin
          or_data_d = ext_val;
          or_tag_d  = pipe_io.tag_in;
`ifdef IMM_EXT_ERR_EN
          or_err_d  = ext_illegal;
`endif
        end
      end
    end else if (accept) begin
      // OR stalled: the new transaction parks in the skid register.
      sk_valid_d = 1'b1;
      sk_data_d  = ext_val;
      sk_tag_d   = pipe_io.tag_in;
`ifdef IMM_EXT_ERR_EN
      sk_err_d   = ext_illegal;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      or_valid_q <= 1'b0;
      or_data_q  <= '0;
      or_tag_q   <= '0;
      sk_valid_q <= 1'b0;
      sk_data_q  <= '0;
      sk_tag_q   <= '0;
`ifdef IMM_EXT_ERR_EN
      or_err_q   <= 1'b0;
      sk_err_q   <= 1'b0;
`endif
    end else begin
      or_valid_q <= or_valid_d;
      or_data_q  <= or_data_d;
      or_tag_q   <= or_tag_d;
      sk_valid_q <= sk_valid_d;
      sk_data_q  <= sk_data_d;
      sk_tag_q   <= sk_tag_d;
`ifdef IMM_EXT_ERR_EN
      or_err_q   <= or_err_d;
      sk_err_q   <= sk_err_d;
`endif
    end
  end

  // -------------------------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------------------------
  assign pipe_io.in_ready  = ~sk_valid_q;
  assign pipe_io.out_valid = or_valid_q;
  assign pipe_io.imm_out   = or_data_q;
  assign pipe_io.tag_out   = or_tag_q;
`ifdef IMM_EXT_ERR_EN
  assign pipe_io.ext_err   = or_valid_q & or_err_q;
`endif

endmodule

// File: tb/tb_imm_ext_pipe.sv
// ---------------------------------------------------------------------------------------------
// tb_imm_ext_pipe
//
// Self-checking bench for imm_ext_pipe. The reference model treats the block as a 2-deep FIFO
// of already-extended results whose head is shown on the output; extension values come from
// plain arithmetic on the immediate. Directed sequences add literal expectations, then a
// randomized run with occasional flush/reset is checked cycle by cycle.
// ---------------------------------------------------------------------------------------------
module tb_imm_ext_pipe;

  localparam int unsigned IMM_W  = 16;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned TAG_W  = 8;

  typedef struct packed {
    logic [DATA_W-1:0] d;
    logic [TAG_W-1:0]  t;
    logic              e;
  } item_t;

  logic clk = 1'b0;
  logic reset;
  logic flush;

  always #5 clk = ~clk;

  imm_ext_pipe_if #(.IMM_W(IMM_W), .DATA_W(DATA_W), .TAG_W(TAG_W)) bus ();

  imm_ext_pipe #(.IMM_W(IMM_W), .DATA_W(DATA_W), .TAG_W(TAG_W)) dut (
    .clk     (clk),
    .reset   (reset),
    .flush   (flush),
    .pipe_io (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  item_t             q[$];
  logic [DATA_W-1:0] last_d = '0;
  logic [TAG_W-1:0]  last_t = '0;
  bit                model_ok = 1'b0;

  function automatic item_t model_ext(input logic [2:0] op, input logic [IMM_W-1:0] imm,
                                      input logic [TAG_W-1:0] tag);
    item_t it;
    int    s;
    s    = $signed(imm);
    it.t = tag;
    it.e = 1'b0;
    case (op)
      3'd0: it.d = 32'(imm);
      3'd1: it.d = s;
      3'd2: it.d = 32'(imm) * 32'd65536;
      3'd3: it.d = s * 4;
      3'd4: it.d = (32'(imm) / 32'd64) % 32'd32;
      default: begin
        it.d = '0;
        it.e = 1'b1;
      end
    endcase
    return it;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    chk("in_ready", 64'(bus.in_ready), 64'(q.size() < 2));
    chk("out_valid", 64'(bus.out_valid), 64'(q.size() != 0));
    chk("imm_out", 64'(bus.imm_out), 64'((q.size() != 0) ? q[0].d : last_d));
    chk("tag_out", 64'(bus.tag_out), 64'((q.size() != 0) ? q[0].t : last_t));
`ifdef IMM_EXT_ERR_EN
    chk("ext_err", 64'(bus.ext_err), 64'((q.size() != 0) ? q[0].e : 1'b0));
`endif
  endtask

  // One clock cycle: drive, compare at negedge, advance model at posedge.
  task automatic step(input bit v, input logic [2:0] op, input logic [IMM_W-1:0] imm,
                      input logic [TAG_W-1:0] tag, input bit ordy, input bit rst, input bit fl);
    bit acc;
    bit con;
    bus.in_valid  = v;
    bus.ExtOp     = op;
    bus.imm_in    = imm;
    bus.tag_in    = tag;
    bus.out_ready = ordy;
    reset         = rst;
    flush         = fl;
    @(negedge clk);
    if (model_ok) compare_model();
    acc = v && (q.size() < 2);
    con = (q.size() != 0) && ordy;
    @(posedge clk);
    if (rst || fl) begin
      q.delete();
      last_d = '0;
      last_t = '0;
      if (rst) model_ok = 1'b1;
    end else begin
      if (con) void'(q.pop_front());
      if (acc) q.push_back(model_ext(op, imm, tag));
      if (q.size() != 0) begin
        last_d = q[0].d;
        last_t = q[0].t;
      end
    end
    #1;
  endtask

  task automatic idle(input bit ordy);
    step(1'b0, 3'd0, '0, '0, ordy, 1'b0, 1'b0);
  endtask

  task automatic push(input logic [2:0] op, input logic [IMM_W-1:0] imm,
                      input logic [TAG_W-1:0] tag, input bit ordy);
    step(1'b1, op, imm, tag, ordy, 1'b0, 1'b0);
  endtask

  logic [DATA_W-1:0] sweep_exp [5];

  initial begin
    sweep_exp[0] = 32'h0000F0C3;
    sweep_exp[1] = 32'hFFFFF0C3;
    sweep_exp[2] = 32'hF0C30000;
    sweep_exp[3] = 32'hFFFFC30C;
    sweep_exp[4] = 32'h00000003;

    bus.in_valid  = 1'b0;
    bus.ExtOp     = '0;
    bus.imm_in    = '0;
    bus.tag_in    = '0;
    bus.out_ready = 1'b0;
    reset         = 1'b1;
    flush         = 1'b0;

    // Reset
    step(1'b0, 3'd0, '0, '0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 3'd0, '0, '0, 1'b0, 1'b1, 1'b0);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_imm_out", 64'(bus.imm_out), 64'd0);
    chk("rst_tag_out", 64'(bus.tag_out), 64'd0);
    idle(1'b1);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);

    // Single sign-extend transaction, 1-cycle latency
    push(3'd1, 16'h8001, 8'h05, 1'b1);
    chk("lat_out_valid", 64'(bus.out_valid), 64'd1);
    chk("lat_imm_out", 64'(bus.imm_out), 64'hFFFF8001);
    chk("lat_tag_out", 64'(bus.tag_out), 64'h05);
    idle(1'b1);
    chk("lat_drained", 64'(bus.out_valid), 64'd0);

    // Mode sweep
    for (int m = 0; m < 5; m++) begin
      push(3'(m), 16'hF0C3, 8'(m), 1'b1);
      chk($sformatf("sweep_mode%0d", m), 64'(bus.imm_out), 64'(sweep_exp[m]));
    end
    idle(1'b1);

    // Back-pressure: tags 1,2 fill OR/SK, tag 3 waits upstream
    push(3'd0, 16'h0001, 8'd1, 1'b0);
    push(3'd0, 16'h0002, 8'd2, 1'b0);
    chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
    chk("bp_head", 64'(bus.tag_out), 64'd1);
    push(3'd0, 16'h0003, 8'd3, 1'b0);
    chk("bp_hold_tag", 64'(bus.tag_out), 64'd1);
    chk("bp_hold_imm", 64'(bus.imm_out), 64'd1);
    push(3'd0, 16'h0003, 8'd3, 1'b1);
    chk("bp_second", 64'(bus.tag_out), 64'd2);
    chk("bp_ready_back", 64'(bus.in_ready), 64'd1);
    push(3'd0, 16'h0003, 8'd3, 1'b1);
    chk("bp_third", 64'(bus.tag_out), 64'd3);
    idle(1'b1);
    chk("bp_empty", 64'(bus.out_valid), 64'd0);

    // Flush with OR and SK full and a new request pending
    push(3'd0, 16'h00A1, 8'hA1, 1'b0);
    push(3'd0, 16'h00A2, 8'hA2, 1'b0);
    step(1'b1, 3'd0, 16'h00A3, 8'hA3, 1'b0, 1'b0, 1'b1);
    chk("fl_out_valid", 64'(bus.out_valid), 64'd0);
    chk("fl_in_ready", 64'(bus.in_ready), 64'd1);
    chk("fl_tag_out", 64'(bus.tag_out), 64'd0);
    idle(1'b1);
    chk("fl_stays_empty", 64'(bus.out_valid), 64'd0);

    // SK full, then consume: SK moves to OR, then a steady stream at one per cycle
    push(3'd0, 16'h0010, 8'h10, 1'b0);
    push(3'd0, 16'h0011, 8'h11, 1'b0);
    push(3'd0, 16'h0012, 8'h12, 1'b1);
    chk("tp_sk_to_or", 64'(bus.tag_out), 64'h11);
    chk("tp_ready", 64'(bus.in_ready), 64'd1);
    for (int k = 8'h12; k <= 8'h15; k++) begin
      push(3'd0, 16'(k), 8'(k), 1'b1);
      chk($sformatf("tp_tag_%0h", k), 64'(bus.tag_out), 64'(k));
      chk($sformatf("tp_valid_%0h", k), 64'(bus.out_valid), 64'd1);
    end
    idle(1'b1);

    // Illegal mode
    push(3'd6, 16'h1234, 8'h77, 1'b1);
    chk("ill_imm_out", 64'(bus.imm_out), 64'd0);
    chk("ill_out_valid", 64'(bus.out_valid), 64'd1);
`ifdef IMM_EXT_ERR_EN
    chk("ill_ext_err", 64'(bus.ext_err), 64'd1);
`endif
    push(3'd1, 16'h0001, 8'h78, 1'b1);
    chk("ill_next_imm", 64'(bus.imm_out), 64'd1);
`ifdef IMM_EXT_ERR_EN
    chk("ill_next_err", 64'(bus.ext_err), 64'd0);
`endif
    idle(1'b1);

    // Randomized traffic with occasional flush and reset
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), 16'($urandom),
           8'($urandom), $urandom_range(0, 2) != 0, $urandom_range(0, 299) == 0,
           $urandom_range(0, 59) == 0);
    end
    idle(1'b1);
    idle(1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
